wb_arb_intercon: RTL and testbench
==================================

WB_ARB_INTERCON -- requirements
Module: wb_arb_intercon

Interface
REQ-001 Parameter DATA_WIDTH, default 32: data bus width; legal values 16 and 32.
REQ-002 Parameter NUM_SLAVES, default 4: slave port count; legal range 1..8.
REQ-003 Parameter SLAVE_MASK, default all zero: NUM_SLAVES*32-bit packed; slice k is the address mask for slave k.
REQ-004 Parameter SLAVE_ADDR, default all zero: NUM_SLAVES*32-bit packed; slice k is the match value for slave k.
REQ-005 Parameter TIMEOUT, default 255: watchdog limit in cycles; legal range 2..65535.
REQ-006 Clocking: one clock; reset is asynchronous and active-low.
REQ-007 clk_i  in  1  rising-edge clock.
REQ-008 rst_n_i  in  1  asynchronous active-low reset.
REQ-009 wbmN_adr_i/dat_i/sel_i/we_i/cyc_i/stb_i, N=0,1  in  32/DATA_WIDTH/DATA_WIDTH/8/1/1/1  master N request.
REQ-010 wbmN_dat_o/ack_o/err_o, N=0,1  out  DATA_WIDTH/1/1  master N response.
REQ-011 wbs_adr_o/dat_o/sel_o/we_o  out  32/DATA_WIDTH/DATA_WIDTH/8/1  shared slave request, sourced from the granted master.
REQ-012 wbs_cyc_o/stb_o  out  NUM_SLAVES each  per-slave cycle and strobe.
REQ-013 wbs_dat_i/ack_i  in  NUM_SLAVES*DATA_WIDTH/NUM_SLAVES  packed slave responses.
REQ-014 gnt_o  out  2  one-hot current grant, 00 when idle.

Function
REQ-015 Arbiter states: IDLE, OWN0, OWN1 (registered).
REQ-016 In IDLE with exactly one cyc_i high: move to that master's OWN state next edge.
REQ-017 In IDLE with both cyc_i high: grant the master not granted last (round-robin); after reset the last-granted flag is 1, so master 0 wins first.
REQ-018 In OWNn: stay while wbmn_cyc_i is high; on wbmn_cyc_i low return to IDLE; no direct OWN0<->OWN1 transition.
REQ-019 Arbitration latency: one cycle from cyc_i rise to grant; no slave strobe during IDLE.
REQ-020 Decode: slave k matches when (adr & MASK_k) == ADDR_k, using the granted master's address; with several matches, the lowest k wins; the selection is one-hot.
REQ-021 wbs_cyc_o[k] = grant active and cyc of granted master and sel_k; wbs_stb_o[k] adds stb of granted master, gated low while an error pulse is asserted.
REQ-022 Granted master's ack_o = ack_i of the selected slave only; acks from unselected slaves are ignored.
REQ-023 Granted master's dat_o = dat_i of the selected slave; zero when no slave is selected.
REQ-024 Non-granted master: ack_o=0, err_o=0, dat_o=0.
REQ-025 Decode error: granted cyc&stb with no match raises err_o for exactly one cycle, on the following cycle; the pulse repeats every other cycle while the strobe is held.
REQ-026 Watchdog: a 16-bit counter increments each cycle the granted strobe is high, a slave is selected, and there is no ack; it clears on ack, on strobe low, or on a grant change.
REQ-027 Counter reaching TIMEOUT: one-cycle err_o to the granted master, slave strobe gated low that cycle, counter cleared.
REQ-028 ack and err never assert together; if a slave ack coincides with the timeout, the ack wins and the counter clears.
REQ-029 A master dropping cyc mid-transfer: the grant releases next edge and the watchdog and error state clear.

Reset
REQ-030 During rst_n_i low: state IDLE, gnt_o=00, last-granted=1, watchdog=0, error pulse=0; all ack_o/err_o/cyc_o/stb_o=0, all dat_o=0.
REQ-031 Reset assertion mid-transfer aborts immediately and asynchronously; the first arbitration after reset release favours master 0.

Verification
REQ-032 M0 reads 0x00001000 with SLAVE_MASK0=0xFFFFF000, SLAVE_ADDR0=0x00001000, slave 0 returning 0xDEADBEEF -> gnt_o=01 one cycle after cyc; wbs_stb_o=0001; wbm0_dat_o=0xDEADBEEF with ack.
REQ-033 M0 and M1 assert cyc in the same cycle, twice in succession with release between -> grants 01 then 10; the loser sees no ack.
REQ-034 M1 strobes an unmapped address -> wbm1_err_o is a single-cycle pulse the next cycle; no wbs_stb_o asserted; wbm1_ack_o=0.
REQ-035 TIMEOUT=4 with the selected slave never acking -> err_o after 4 strobe cycles; stb_o low in the err cycle.
REQ-036 Two slaves match overlapping ranges -> only the lower index strobed and its data returned.
REQ-037 rst_n_i pulsed low mid-transfer -> all outputs zero asynchronously; after release, a simultaneous request grants M0.

Source files
------------

// File: rtl/wb_arb_intercon.sv
// Two-master Wishbone interconnect: round-robin arbiter, mask/match address decode
// to NUM_SLAVES slaves, decode-error responder and per-transfer watchdog.
module wb_arb_intercon #(
  parameter int                        DATA_WIDTH = 32,
  parameter int                        NUM_SLAVES = 4,
  parameter logic [NUM_SLAVES*32-1:0]  SLAVE_MASK = '0,
  parameter logic [NUM_SLAVES*32-1:0]  SLAVE_ADDR = '0,
  parameter int                        TIMEOUT    = 255
) (
  input  logic                             clk_i,
  input  logic                             rst_n_i,

  input  logic [31:0]                      wbm0_adr_i,
  input  logic [DATA_WIDTH-1:0]            wbm0_dat_i,
  input  logic [DATA_WIDTH/8-1:0]          wbm0_sel_i,
  input  logic                             wbm0_we_i,
  input  logic                             wbm0_cyc_i,
  input  logic                             wbm0_stb_i,
  output logic [DATA_WIDTH-1:0]            wbm0_dat_o,
  output logic                             wbm0_ack_o,
  output logic                             wbm0_err_o,

  input  logic [31:0]                      wbm1_adr_i,
  input  logic [DATA_WIDTH-1:0]            wbm1_dat_i,
  input  logic [DATA_WIDTH/8-1:0]          wbm1_sel_i,
  input  logic                             wbm1_we_i,
  input  logic                             wbm1_cyc_i,
  input  logic                             wbm1_stb_i,
  output logic [DATA_WIDTH-1:0]            wbm1_dat_o,
  output logic                             wbm1_ack_o,
  output logic                             wbm1_err_o,

  output logic [31:0]                      wbs_adr_o,
  output logic [DATA_WIDTH-1:0]            wbs_dat_o,
  output logic [DATA_WIDTH/8-1:0]          wbs_sel_o,
  output logic                             wbs_we_o,
  output logic [NUM_SLAVES-1:0]            wbs_cyc_o,
  output logic [NUM_SLAVES-1:0]            wbs_stb_o,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] wbs_dat_i,
  input  logic [NUM_SLAVES-1:0]            wbs_ack_i,

  output logic [1:0]                       gnt_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] OWN0 = 2'd1;
  localparam logic [1:0] OWN1 = 2'd2;

  logic [1:0]             state, state_nxt;
  logic                   last_gnt;
  logic [15:0]            wd_cnt;
  logic                   err_q;

  logic                   gnt0, gnt1, granted;
  logic [31:0]            g_adr;
  logic [DATA_WIDTH-1:0]  g_dat;
  logic [DATA_WIDTH/8-1:0] g_sel;
  logic                   g_we, g_cyc, g_stb;

  logic [NUM_SLAVES-1:0]  slave_sel;
  logic                   hit;
  logic [DATA_WIDTH-1:0]  sel_dat;
  logic                   sel_ack;
  logic                   req, dec_err, wd_hit, grant_change;

  // Ownership holds for the whole cycle; both masters pass through IDLE between grants.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (wbm0_cyc_i && wbm1_cyc_i) state_nxt = last_gnt ? OWN0 : OWN1;
        else if (wbm0_cyc_i)          state_nxt = OWN0;
        else if (wbm1_cyc_i)          state_nxt = OWN1;
      end
      OWN0:    if (!wbm0_cyc_i) state_nxt = IDLE;
      OWN1:    if (!wbm1_cyc_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign gnt0    = (state == OWN0);
  assign gnt1    = (state == OWN1);
  assign granted = gnt0 | gnt1;
  assign gnt_o   = {gnt1, gnt0};

  always_comb begin
    g_adr = '0;
    g_dat = '0;
    g_sel = '0;
    g_we  = 1'b0;
    g_cyc = 1'b0;
    g_stb = 1'b0;
    if (gnt0) begin
      g_adr = wbm0_adr_i;
      g_dat = wbm0_dat_i;
      g_sel = wbm0_sel_i;
      g_we  = wbm0_we_i;
      g_cyc = wbm0_cyc_i;
      g_stb = wbm0_stb_i;
    end else if (gnt1) begin
      g_adr = wbm1_adr_i;
      g_dat = wbm1_dat_i;
      g_sel = wbm1_sel_i;
      g_we  = wbm1_we_i;
      g_cyc = wbm1_cyc_i;
      g_stb = wbm1_stb_i;
    end
  end

  // Lowest matching index wins, keeping the selection one-hot on overlapping ranges.
  always_comb begin
    logic found;
    found     = 1'b0;
    slave_sel = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (!found && ((g_adr & SLAVE_MASK[k*32 +: 32]) == SLAVE_ADDR[k*32 +: 32])) begin
        slave_sel[k] = 1'b1;
        found        = 1'b1;
      end
    end
  end

  always_comb begin
    sel_dat = '0;
    sel_ack = 1'b0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (slave_sel[k]) begin
        sel_dat = wbs_dat_i[k*DATA_WIDTH +: DATA_WIDTH];
        sel_ack = wbs_ack_i[k];
      end
    end
  end

  assign hit          = |slave_sel;
  assign req          = granted & g_cyc & g_stb;
  assign grant_change = (state_nxt != state);
  assign dec_err      = req & ~hit & ~err_q;
  assign wd_hit       = req & hit & ~sel_ack & ~err_q & (wd_cnt == 16'(TIMEOUT - 1));

  // Error pulses are registered so they land one cycle after the offending strobe.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state    <= IDLE;
      last_gnt <= 1'b1;
      wd_cnt   <= '0;
      err_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && state_nxt == OWN0) last_gnt <= 1'b0;
      else if (state == IDLE && state_nxt == OWN1) last_gnt <= 1'b1;
      err_q <= ~grant_change & (dec_err | wd_hit);
      if (grant_change || !req || !hit || sel_ack || err_q || wd_hit) wd_cnt <= '0;
      else                                                            wd_cnt <= wd_cnt + 16'd1;
    end
  end

  assign wbs_adr_o = g_adr;
  assign wbs_dat_o = g_dat;
  assign wbs_sel_o = g_sel;
  assign wbs_we_o  = g_we;
  assign wbs_cyc_o = {NUM_SLAVES{granted & g_cyc}} & slave_sel;
  assign wbs_stb_o = wbs_cyc_o & {NUM_SLAVES{g_stb & ~err_q}};

  assign wbm0_ack_o = gnt0 & sel_ack & ~err_q;
  assign wbm1_ack_o = gnt1 & sel_ack & ~err_q;
  assign wbm0_err_o = gnt0 & err_q;
  assign wbm1_err_o = gnt1 & err_q;
  assign wbm0_dat_o = gnt0 ? sel_dat : '0;
  assign wbm1_dat_o = gnt1 ? sel_dat : '0;

endmodule

// File: tb/tb_wb_arb_intercon.sv
// Directed bench for wb_arb_intercon: arbitration, decode, decode error,
// watchdog timeout and asynchronous reset behaviour.
module tb_wb_arb_intercon;

  localparam int DW = 32;
  localparam int NS = 4;
  localparam logic [NS*32-1:0] MASKS = {32'hFF000000, 32'hFFFFF000, 32'hFFFF0000, 32'hFFFFF000};
  localparam logic [NS*32-1:0] ADDRS = {32'h10000000, 32'h00002000, 32'h00000000, 32'h00001000};

  logic            clk_i = 1'b0;
  logic            rst_n_i;
  logic [31:0]     m0_adr, m1_adr;
  logic [DW-1:0]   m0_wdat, m1_wdat;
  logic [DW/8-1:0] m0_sel, m1_sel;
  logic            m0_we, m1_we, m0_cyc, m1_cyc, m0_stb, m1_stb;
  logic [DW-1:0]   m0_rdat, m1_rdat;
  logic            m0_ack, m1_ack, m0_err, m1_err;
  logic [31:0]     s_adr;
  logic [DW-1:0]   s_wdat;
  logic [DW/8-1:0] s_sel;
  logic            s_we;
  logic [NS-1:0]   s_cyc, s_stb, s_ack;
  logic [NS*DW-1:0] s_rdat;
  logic [1:0]      gnt;
  logic [NS-1:0]   ack_en, force_ack;
  int              checks = 0;
  int              failures = 0;

  always #5 clk_i = ~clk_i;

  // Zero-wait-state slaves: ack whenever strobed and enabled.
  assign s_ack  = (s_stb & ack_en) | force_ack;
  assign s_rdat = {32'h33333333, 32'h22222222, 32'h11111111, 32'hDEADBEEF};

  wb_arb_intercon #(
    .DATA_WIDTH(DW), .NUM_SLAVES(NS), .SLAVE_MASK(MASKS), .SLAVE_ADDR(ADDRS), .TIMEOUT(4)
  ) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .wbm0_adr_i(m0_adr), .wbm0_dat_i(m0_wdat), .wbm0_sel_i(m0_sel), .wbm0_we_i(m0_we),
    .wbm0_cyc_i(m0_cyc), .wbm0_stb_i(m0_stb),
    .wbm0_dat_o(m0_rdat), .wbm0_ack_o(m0_ack), .wbm0_err_o(m0_err),
    .wbm1_adr_i(m1_adr), .wbm1_dat_i(m1_wdat), .wbm1_sel_i(m1_sel), .wbm1_we_i(m1_we),
    .wbm1_cyc_i(m1_cyc), .wbm1_stb_i(m1_stb),
    .wbm1_dat_o(m1_rdat), .wbm1_ack_o(m1_ack), .wbm1_err_o(m1_err),
    .wbs_adr_o(s_adr), .wbs_dat_o(s_wdat), .wbs_sel_o(s_sel), .wbs_we_o(s_we),
    .wbs_cyc_o(s_cyc), .wbs_stb_o(s_stb), .wbs_dat_i(s_rdat), .wbs_ack_i(s_ack),
    .gnt_o(gnt)
  );

  task automatic applyStimulus(input int m, input logic cyc, input logic stb, input logic [31:0] adr);
    if (m == 0) begin
      m0_cyc = cyc; m0_stb = stb; m0_adr = adr; m0_we = 1'b0; m0_sel = '1; m0_wdat = 32'hA5A50000;
    end else begin
      m1_cyc = cyc; m1_stb = stb; m1_adr = adr; m1_we = 1'b0; m1_sel = '1; m1_wdat = 32'h5A5A0000;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_n_i = 1'b0; ack_en = '1; force_ack = '0;
    applyStimulus(0, 1'b1, 1'b1, 32'h00001000);
    applyStimulus(1, 1'b1, 1'b1, 32'h00001000);
    tick();
    checkOutput("reset_gnt", 32'(gnt), 32'h0);
    checkOutput("reset_stb", 32'(s_stb), 32'h0);
    checkOutput("reset_cyc", 32'(s_cyc), 32'h0);
    checkOutput("reset_ack", 32'({m0_ack, m1_ack, m0_err, m1_err}), 32'h0);
    checkOutput("reset_dat", m0_rdat | m1_rdat, 32'h0);
    applyStimulus(0, 1'b0, 1'b0, 32'h0);
    applyStimulus(1, 1'b0, 1'b0, 32'h0);
    rst_n_i = 1'b1;
    tick();

    // Simultaneous requests: master 0 first, then master 1.
    applyStimulus(0, 1'b1, 1'b1, 32'h00001000);
    applyStimulus(1, 1'b1, 1'b1, 32'h00001000);
    #1;
    checkOutput("rr_idle_gnt", 32'(gnt), 32'h0);
    checkOutput("rr_idle_stb", 32'(s_stb), 32'h0);
    tick();
    checkOutput("rr1_gnt", 32'(gnt), 32'h1);
    checkOutput("rr1_m0_ack", 32'(m0_ack), 32'h1);
    checkOutput("rr1_m1_ack", 32'(m1_ack), 32'h0);
    checkOutput("rr1_m1_dat", m1_rdat, 32'h0);
    applyStimulus(0, 1'b0, 1'b0, 32'h0);
    applyStimulus(1, 1'b0, 1'b0, 32'h0);
    tick();
    checkOutput("rr_rel_gnt", 32'(gnt), 32'h0);
    applyStimulus(0, 1'b1, 1'b1, 32'h00001000);
    applyStimulus(1, 1'b1, 1'b1, 32'h00001000);
    tick();
    checkOutput("rr2_gnt", 32'(gnt), 32'h2);
    checkOutput("rr2_m1_ack", 32'(m1_ack), 32'h1);
    checkOutput("rr2_m1_dat", m1_rdat, 32'hDEADBEEF);
    checkOutput("rr2_m0_ack", 32'(m0_ack), 32'h0);
    checkOutput("rr2_m0_dat", m0_rdat, 32'h0);
    applyStimulus(0, 1'b0, 1'b0, 32'h0);
    applyStimulus(1, 1'b0, 1'b0, 32'h0);
    tick();

    // Single read by master 0, then overlap/other-slave decode.
    applyStimulus(0, 1'b1, 1'b1, 32'h00001000);
    #1;
    checkOutput("rd_lat_gnt", 32'(gnt), 32'h0);
    tick();
    checkOutput("rd_gnt", 32'(gnt), 32'h1);
    checkOutput("rd_stb_overlap", 32'(s_stb), 32'h1);
    checkOutput("rd_cyc_overlap", 32'(s_cyc), 32'h1);
    checkOutput("rd_dat", m0_rdat, 32'hDEADBEEF);
    checkOutput("rd_ack", 32'(m0_ack), 32'h1);
    checkOutput("rd_adr", s_adr, 32'h00001000);
    applyStimulus(0, 1'b1, 1'b1, 32'h00003000);
    #1;
    checkOutput("dec1_stb", 32'(s_stb), 32'h2);
    checkOutput("dec1_dat", m0_rdat, 32'h11111111);
    applyStimulus(0, 1'b1, 1'b1, 32'h10000040);
    #1;
    checkOutput("dec3_stb", 32'(s_stb), 32'h8);
    checkOutput("dec3_dat", m0_rdat, 32'h33333333);
    applyStimulus(0, 1'b0, 1'b0, 32'h0);
    tick();
    checkOutput("rd_rel_gnt", 32'(gnt), 32'h0);

    // Unmapped address from master 1.
    applyStimulus(1, 1'b1, 1'b1, 32'h20000000);
    tick();
    checkOutput("ue_c0_gnt", 32'(gnt), 32'h2);
    checkOutput("ue_c0_err", 32'(m1_err), 32'h0);
    checkOutput("ue_c0_stb", 32'(s_stb), 32'h0);
    checkOutput("ue_c0_cyc", 32'(s_cyc), 32'h0);
    tick();
    checkOutput("ue_c1_err", 32'(m1_err), 32'h1);
    checkOutput("ue_c1_ack", 32'(m1_ack), 32'h0);
    checkOutput("ue_c1_dat", m1_rdat, 32'h0);
    checkOutput("ue_c1_m0_err", 32'(m0_err), 32'h0);
    tick();
    checkOutput("ue_c2_err", 32'(m1_err), 32'h0);
    tick();
    checkOutput("ue_c3_err", 32'(m1_err), 32'h1);
    applyStimulus(1, 1'b0, 1'b0, 32'h0);
    tick();
    checkOutput("ue_rel_err", 32'(m1_err), 32'h0);
    checkOutput("ue_rel_gnt", 32'(gnt), 32'h0);

    // Watchdog with slave 0 silent; stray ack from unselected slave 1.
    ack_en = 4'b1110;
    applyStimulus(0, 1'b1, 1'b1, 32'h00001000);
    tick();
    checkOutput("to_c0_stb", 32'(s_stb), 32'h1);
    checkOutput("to_c0_err", 32'(m0_err), 32'h0);
    tick();
    force_ack = 4'b0010;
    #1;
    checkOutput("to_unsel_ack", 32'(m0_ack), 32'h0);
    force_ack = '0;
    tick();
    checkOutput("to_c2_err", 32'(m0_err), 32'h0);
    tick();
    checkOutput("to_c3_err", 32'(m0_err), 32'h0);
    checkOutput("to_c3_stb", 32'(s_stb), 32'h1);
    tick();
    checkOutput("to_c4_err", 32'(m0_err), 32'h1);
    checkOutput("to_c4_stb", 32'(s_stb), 32'h0);
    checkOutput("to_c4_ack", 32'(m0_ack), 32'h0);
    tick();
    checkOutput("to_c5_err", 32'(m0_err), 32'h0);
    checkOutput("to_c5_stb", 32'(s_stb), 32'h1);
    tick();
    tick();
    tick();
    ack_en = 4'b1111;
    #1;
    checkOutput("co_ack", 32'(m0_ack), 32'h1);
    checkOutput("co_err", 32'(m0_err), 32'h0);
    tick();
    checkOutput("co_next_err", 32'(m0_err), 32'h0);
    applyStimulus(0, 1'b0, 1'b0, 32'h0);
    tick();

    // Asynchronous reset in the middle of a master 0 transfer.
    applyStimulus(0, 1'b1, 1'b1, 32'h00001000);
    tick();
    checkOutput("pre_rst_gnt", 32'(gnt), 32'h1);
    applyStimulus(1, 1'b1, 1'b1, 32'h00001000);
    #2;
    rst_n_i = 1'b0;
    #1;
    checkOutput("arst_gnt", 32'(gnt), 32'h0);
    checkOutput("arst_stb", 32'(s_stb), 32'h0);
    checkOutput("arst_cyc", 32'(s_cyc), 32'h0);
    checkOutput("arst_ack", 32'({m0_ack, m1_ack, m0_err, m1_err}), 32'h0);
    checkOutput("arst_dat", m0_rdat | m1_rdat, 32'h0);
    tick();
    rst_n_i = 1'b1;
    tick();
    checkOutput("post_rst_gnt", 32'(gnt), 32'h1);
    applyStimulus(0, 1'b0, 1'b0, 32'h0);
    applyStimulus(1, 1'b0, 1'b0, 32'h0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
